stopit_round_ctrl: RTL and testbench

- Round controller for the StopIt game. Sits directly upstream of the 5-bit time counter and drives that counter's enable and synchronous clear.
- Picks a pseudo-random target with a free-running LFSR, then starts the count. When the player hits stop it freezes the count, judges the stopped value against the target, and keeps a saturating win tally.

---
 rtl/stopit_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stopit_round_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopit_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopit_round_ctrl
// Brief    : StopIt round controller - draws a target, runs the time counter,
//            judges the stopped value and keeps a saturating win tally.
// Revision : 1.0 - initial release
// ============================================================================
module stopit_round_ctrl #(
   parameter int         TOLERANCE  = 0,
   parameter int         MIN_TARGET = 4,
   parameter logic [4:0] LFSR_SEED  = 5'h01
) (
   input  logic       clk_4_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic [4:0] count_i,
   output logic       counter_en_o,
   output logic       counter_rst_no,
   output logic [4:0] target_o,
   output logic [4:0] stopped_o,
   output logic       running_o,
   output logic       win_o,
   output logic       lose_o,
   output logic [3:0] wins_o
);

   localparam logic [4:0] c_MIN_TARGET = 5'(MIN_TARGET);
   localparam logic [5:0] c_TOLERANCE  = 6'(TOLERANCE);
   localparam logic [4:0] c_COUNT_MAX  = 5'd31;
   localparam logic [3:0] c_WINS_MAX   = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_WIN     = 2'd2,
      S_LOSE    = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_start_q;
   logic       r_stop_q;
   logic [4:0] r_lfsr;
   logic [4:0] r_target;
   logic [4:0] r_stopped;
   logic [3:0] r_wins;

   logic       w_start_edge;
   logic       w_stop_edge;
   logic       w_at_max;
   logic [4:0] w_draw;
   logic [5:0] w_diff;
   logic [5:0] w_abs;
   logic       w_hit;
   logic       w_round_start;
   logic       w_judge;
   logic       w_timeout;
   logic       w_win_entry;

   assign w_start_edge = start_i & ~r_start_q;
   assign w_stop_edge  = stop_i & ~r_stop_q;
   assign w_at_max     = (count_i == c_COUNT_MAX);

   // Small draws are lifted so the player always has a few ticks to react.
   assign w_draw = (r_lfsr < c_MIN_TARGET) ? (r_lfsr + c_MIN_TARGET) : r_lfsr;

   // Zero-extended two's-complement difference; magnitude always fits 5 bits.
   assign w_diff = {1'b0, count_i} - {1'b0, r_target};
   assign w_abs  = w_diff[5] ? (~w_diff + 6'd1) : w_diff;
   assign w_hit  = (w_abs <= c_TOLERANCE);

   always_ff @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_round_start = 1'b0;
      w_judge       = 1'b0;
      w_timeout     = 1'b0;
      w_win_entry   = 1'b0;
      counter_en_o  = 1'b0;
      running_o     = 1'b0;
      win_o         = 1'b0;
      lose_o        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_round_start = 1'b1;
               w_state_nxt   = S_RUNNING;
            end
         end
         S_RUNNING: begin
            running_o    = 1'b1;
            counter_en_o = ~w_stop_edge & ~w_at_max;
            if (w_stop_edge) begin
               w_judge = 1'b1;
               if (w_hit) begin
                  w_win_entry = 1'b1;
                  w_state_nxt = S_WIN;
               end else begin
                  w_state_nxt = S_LOSE;
               end
            end else if (w_at_max) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_LOSE;
            end
         end
         S_WIN: begin
            win_o = 1'b1;
            if (w_start_edge) begin
               w_round_start = 1'b1;
               w_state_nxt   = S_RUNNING;
            end
         end
         S_LOSE: begin
            lose_o = 1'b1;
            if (w_start_edge) begin
               w_round_start = 1'b1;
               w_state_nxt   = S_RUNNING;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The counter is held cleared throughout reset and for the round-start cycle.
   assign counter_rst_no = ~rst_i & ~w_round_start;

   always_ff @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) begin
         r_start_q <= 1'b0;
         r_stop_q  <= 1'b0;
         r_lfsr    <= LFSR_SEED;
         r_target  <= 5'd0;
         r_stopped <= 5'd0;
         r_wins    <= 4'd0;
      end else begin
         r_start_q <= start_i;
         r_stop_q  <= stop_i;
         r_lfsr    <= {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
         if (w_round_start) begin
            r_target <= w_draw;
         end
         if (w_judge) begin
            r_stopped <= count_i;
         end else if (w_timeout) begin
            r_stopped <= c_COUNT_MAX;
         end
         if (w_win_entry && (r_wins != c_WINS_MAX)) begin
            r_wins <= r_wins + 4'd1;
         end
      end
   end

   assign target_o  = r_target;
   assign stopped_o = r_stopped;
   assign wins_o    = r_wins;

endmodule
`default_nettype wire

// File: tb/tb_stopit_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopit_round_ctrl
// Brief    : Scoreboard bench for stopit_round_ctrl, two tolerance settings
//            sharing one stimulus stream, each with its own time counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopit_round_ctrl;

   typedef struct {
      logic       win;
      logic [4:0] stopped;
      logic [3:0] wins;
   } exp_t;

   logic clk;
   logic rst;
   logic start;
   logic stop;

   logic [4:0] cnt0, cnt2;
   logic       en0, rstn0, run0, win0, lose0;
   logic       en2, rstn2, run2, win2, lose2;
   logic [4:0] tgt0, stp0, tgt2, stp2;
   logic [3:0] wins0, wins2;

   logic [4:0] m_lfsr;
   exp_t       q0[$];
   exp_t       q2[$];
   exp_t       e0, e2;
   logic       prev_run0, prev_run2;
   int         checks;
   int         failures;
   int         exp_w0, exp_w2;

   stopit_round_ctrl #(.TOLERANCE(0), .MIN_TARGET(4), .LFSR_SEED(5'h01)) u_dut0 (
      .clk_4_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .count_i(cnt0),
      .counter_en_o(en0), .counter_rst_no(rstn0), .target_o(tgt0), .stopped_o(stp0),
      .running_o(run0), .win_o(win0), .lose_o(lose0), .wins_o(wins0)
   );

   stopit_round_ctrl #(.TOLERANCE(2), .MIN_TARGET(4), .LFSR_SEED(5'h01)) u_dut2 (
      .clk_4_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .count_i(cnt2),
      .counter_en_o(en2), .counter_rst_no(rstn2), .target_o(tgt2), .stopped_o(stp2),
      .running_o(run2), .win_o(win2), .lose_o(lose2), .wins_o(wins2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream 5-bit time counters with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rstn0) cnt0 <= 5'd0;
      else if (en0) cnt0 <= cnt0 + 5'd1;
      if (!rstn2) cnt2 <= 5'd0;
      else if (en2) cnt2 <= cnt2 + 5'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 5'h01;
      else     m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
   end

   function automatic logic [4:0] draw(input logic [4:0] l);
      return (l < 5'd4) ? l + 5'd4 : l;
   endfunction

   function automatic int sat_inc(input int w);
      return (w >= 15) ? 15 : w + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Judgement monitors: a result is presented when RUNNING ends in WIN or LOSE.
   always @(negedge clk) begin
      if (prev_run0 && (win0 || lose0)) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_judgement", 32'd1, 32'd0);
         end else begin
            e0 = q0.pop_front();
            chk("dut0_win", {31'd0, win0}, {31'd0, e0.win});
            chk("dut0_lose", {31'd0, lose0}, {31'd0, ~e0.win});
            chk("dut0_stopped", {27'd0, stp0}, {27'd0, e0.stopped});
            chk("dut0_wins", {28'd0, wins0}, {28'd0, e0.wins});
         end
      end
      prev_run0 = run0;
   end

   always @(negedge clk) begin
      if (prev_run2 && (win2 || lose2)) begin
         if (q2.size() == 0) begin
            chk("dut2_unexpected_judgement", 32'd1, 32'd0);
         end else begin
            e2 = q2.pop_front();
            chk("dut2_win", {31'd0, win2}, {31'd0, e2.win});
            chk("dut2_lose", {31'd0, lose2}, {31'd0, ~e2.win});
            chk("dut2_stopped", {27'd0, stp2}, {27'd0, e2.stopped});
            chk("dut2_wins", {28'd0, wins2}, {28'd0, e2.wins});
         end
      end
      prev_run2 = run2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(output logic [4:0] t);
      start = 1'b1;
      t = draw(m_lfsr);
      #1;
      chk("round_start_clear", {31'd0, rstn0}, 32'd0);
      tick();
      start = 1'b0;
      chk("target_latch", {27'd0, tgt0}, {27'd0, t});
      chk("first_count", {27'd0, cnt0}, 32'd0);
      chk("running", {31'd0, run0}, 32'd1);
   endtask

   task automatic run_to(input logic [4:0] v);
      int n;
      n = 0;
      while (cnt0 !== v && n < 40) begin
         tick();
         n++;
      end
      chk("count_reached", {27'd0, cnt0}, {27'd0, v});
   endtask

   task automatic push_exp(input logic w0, input logic w2, input logic [4:0] s);
      if (w0) exp_w0 = sat_inc(exp_w0);
      if (w2) exp_w2 = sat_inc(exp_w2);
      q0.push_back('{win: w0, stopped: s, wins: 4'(exp_w0)});
      q2.push_back('{win: w2, stopped: s, wins: 4'(exp_w2)});
   endtask

   task automatic press_stop(input logic w0, input logic w2);
      stop = 1'b1;
      push_exp(w0, w2, cnt0);
      #1;
      chk("en_low_on_stop", {31'd0, en0}, 32'd0);
      tick();
   endtask

   initial begin
      logic [4:0] t;
      checks = 0; failures = 0; exp_w0 = 0; exp_w2 = 0;
      prev_run0 = 1'b0; prev_run2 = 1'b0;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      repeat (3) tick();
      chk("reset_rst_n", {31'd0, rstn0}, 32'd0);
      chk("reset_en", {31'd0, en0}, 32'd0);
      chk("reset_target", {27'd0, tgt0}, 32'd0);
      chk("reset_stopped", {27'd0, stp0}, 32'd0);
      chk("reset_wins", {28'd0, wins0}, 32'd0);
      chk("reset_indicators", {29'd0, run0, win0, lose0}, 32'd0);

      // Round 1: seed 1 draws target 5; exact stop wins on both tolerances.
      rst = 1'b0;
      do_start(t);
      chk("first_target_5", {27'd0, tgt0}, 32'd5);
      chk("first_en", {31'd0, en0}, 32'd1);
      run_to(5'd5);
      press_stop(1'b1, 1'b1);
      stop = 1'b0;
      repeat (3) tick();
      chk("count_holds_5", {27'd0, cnt0}, 32'd5);
      chk("en_idle_after_win", {31'd0, en0}, 32'd0);

      // Reset mid-round at count 12.
      do_start(t);
      run_to(5'd12);
      rst = 1'b1;
      #1;
      chk("midrst_indicators", {29'd0, run0, win0, lose0}, 32'd0);
      chk("midrst_en", {31'd0, en0}, 32'd0);
      chk("midrst_rst_n", {31'd0, rstn0}, 32'd0);
      chk("midrst_wins", {28'd0, wins0}, 32'd0);
      chk("midrst_target", {27'd0, tgt0}, 32'd0);
      exp_w0 = 0; exp_w2 = 0;
      repeat (2) tick();

      // Target 5 again; stop at 7: loses at tolerance 0, wins at tolerance 2.
      rst = 1'b0;
      do_start(t);
      chk("second_target_5", {27'd0, tgt2}, 32'd5);
      run_to(5'd7);
      press_stop(1'b0, 1'b1);
      stop = 1'b0;
      tick();

      // Timeout: never stop.
      do_start(t);
      push_exp(1'b0, 1'b0, 5'd31);
      run_to(5'd31);
      chk("en_low_at_31", {31'd0, en0}, 32'd0);
      repeat (4) tick();
      chk("no_wrap", {27'd0, cnt0}, 32'd31);

      // Sixteen exact stops saturate the tally; the last stop stays held.
      for (int i = 0; i < 16; i++) begin
         do_start(t);
         run_to(t);
         press_stop(1'b1, 1'b1);
         if (i != 15) stop = 1'b0;
         tick();
      end
      chk("wins_saturated", {28'd0, wins0}, 32'd15);

      do_start(t);
      repeat (6) tick();
      chk("held_stop_running", {31'd0, run0}, 32'd1);
      chk("held_stop_count", {27'd0, cnt0}, 32'd6);
      stop = 1'b0;
      push_exp(1'b0, 1'b0, 5'd31);
      run_to(5'd31);

      repeat (3) tick();
      chk("queue0_drained", q0.size(), 32'd0);
      chk("queue2_drained", q2.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
